// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO between EX/MEM and a single-port data memory.
// Define STORE_FWD_EN to forward load hits from the buffer; otherwise load hits stall until drained.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       memRead_i,
    input  logic                       memWrite_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       stall_o,
    output logic                       mem_memRead_o,
    output logic                       mem_memWrite_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d, cnt;
    logic              is_store, is_load, full, hit, miss, drain, enq;
`ifdef STORE_FWD_EN
    logic [DATA_W-1:0] fwd_data;
`endif

    always_comb begin
        cnt      = rst_i ? '0 : count_q;
        is_store = memWrite_i;
        is_load  = memRead_i & ~memWrite_i;
        full     = cnt == CNT_W'(DEPTH);
        hit      = 1'b0;
`ifdef STORE_FWD_EN
        fwd_data = '0;
`endif
        // scan oldest to youngest so the youngest match wins
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < cnt && addr_q[head_q + PTR_W'(k)] == addr_i) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                fwd_data = data_q[head_q + PTR_W'(k)];
`endif
            end
        end
        miss           = is_load & ~hit;
        drain          = (cnt != '0) & ~miss;
        enq            = is_store & ~full & ~rst_i;
        mem_memRead_o  = miss;
        mem_memWrite_o = drain;
        mem_addr_o     = miss ? addr_i : drain ? addr_q[head_q] : '0;
        mem_wdata_o    = drain ? data_q[head_q] : '0;
`ifdef STORE_FWD_EN
        stall_o        = is_store & full;
        rdata_o        = is_load ? (hit ? fwd_data : mem_rdata_i) : '0;
`else
        stall_o        = (is_store & full) | (is_load & hit);
        rdata_o        = miss ? mem_rdata_i : '0;
`endif
        empty_o        = cnt == '0;
        count_o        = cnt;
        head_d         = head_q + PTR_W'(drain);
        tail_d         = tail_q + PTR_W'(enq);
        count_d        = count_q + CNT_W'(enq) - CNT_W'(drain);
        addr_d         = addr_q;
        data_d         = data_q;
        if (enq) begin
            addr_d[tail_q] = addr_i;
            data_d[tail_q] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule
